event_encoder_8_to_3: RTL and testbench

Sequential 8-to-3 encoder, the inverse of the 3-to-8 decoder path. It captures rising edges on eight request lines into a pending register. It presents the highest-priority pending, unmasked request as a 3-bit code over a valid/ready handshake and clears that request's pending bit when the code is accepted. Typical use is to collapse eight event sources onto one code bus that feeds a downstream decoder or controller.

---
 rtl/encoder_pkg.sv | 30 +++
 rtl/event_encoder_8_to_3_if.sv | 24 ++
 rtl/prio_enc8.sv | 31 +++
 rtl/event_encoder_8_to_3.sv | 91 +++++++++
 tb/tb_event_encoder_8_to_3.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/encoder_pkg.sv
// Shared constants, FSM state type and code/one-hot helpers for the event encoder.
// code_to_onehot is also used by the matching 3-to-8 decoder.
package encoder_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned CODE_W = 3;

  typedef enum logic [0:0] {
    StIdle,
    StPresent
  } state_e;

  function automatic logic [N_REQ-1:0] code_to_onehot(input logic [CODE_W-1:0] c);
    logic [N_REQ-1:0] oh;
    oh    = '0;
    oh[c] = 1'b1;
    return oh;
  endfunction

  // Assumes at most one bit set; an all-zero input maps to code 0.
  function automatic logic [CODE_W-1:0] onehot_to_code(input logic [N_REQ-1:0] oh);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (oh[i]) c = c | CODE_W'(i);
    end
    return c;
  endfunction

endpackage

// File: rtl/event_encoder_8_to_3_if.sv
// Request/code bus of the event encoder; master is the encoder, slave the surrounding logic.
interface event_encoder_8_to_3_if;
  import encoder_pkg::*;

  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  mask;
  logic              ready;
  logic              clr_ovf;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic [N_REQ-1:0]  pending;
  logic [N_REQ-1:0]  ovf;

  modport master (
    input  req, mask, ready, clr_ovf,
    output code, valid, pending, ovf
  );

  modport slave (
    output req, mask, ready, clr_ovf,
    input  code, valid, pending, ovf
  );

endinterface

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority encoder; PRIORITY_HIGH=1 favours index 7, 0 favours index 0.
module prio_enc8
  import encoder_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic [N_REQ-1:0]  req,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  logic [N_REQ-1:0] grant;

  // Later matches overwrite earlier ones, so scan direction sets the winner.
  always_comb begin
    grant = '0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (req[i]) grant = code_to_onehot(CODE_W'(i));
      end
    end else begin
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
        if (req[i]) grant = code_to_onehot(CODE_W'(i));
      end
    end
  end

  assign code = onehot_to_code(grant);
  assign any  = |req;

endmodule

// File: rtl/event_encoder_8_to_3.sv
// Sequential 8-to-3 event encoder: latches rising request edges as pending and presents the
// winning unmasked pending index over a valid/ready handshake, clearing it on accept.
module event_encoder_8_to_3
  import encoder_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  event_encoder_8_to_3_if.master bus
);

  logic [N_REQ-1:0]  req_q;
  logic [N_REQ-1:0]  pending_q;
  logic [N_REQ-1:0]  pending_d;
  logic [N_REQ-1:0]  ovf_q;
  logic [N_REQ-1:0]  ovf_d;
  logic [N_REQ-1:0]  rise;
  logic [N_REQ-1:0]  acc_clr;
  logic [N_REQ-1:0]  acc_clr_excl;
  logic [N_REQ-1:0]  cand;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] cand_code;
  logic              valid_q;
  logic              accept;
  logic              cand_any;
  state_e            state_q;

  assign rise      = bus.req & ~req_q;
  assign accept    = valid_q & bus.ready;
  assign acc_clr   = accept ? code_to_onehot(code_q) : '0;
  assign pending_d = (pending_q & ~acc_clr) | rise;
  assign ovf_d     = (bus.clr_ovf ? '0 : ovf_q) | (rise & pending_q & ~acc_clr);

  // Selection runs on the registered pending set, so a new edge costs two cycles; the index
  // being accepted stays eligible only if it rose again in the same cycle.
  assign acc_clr_excl = acc_clr & ~rise;
  assign cand         = pending_q & bus.mask & ~acc_clr_excl;

  prio_enc8 #(
    .PRIORITY_HIGH(PRIORITY_HIGH)
  ) u_prio (
    .req (cand),
    .code(cand_code),
    .any (cand_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= bus.req;
      pending_q <= '0;
      ovf_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      state_q   <= StIdle;
    end else begin
      req_q     <= bus.req;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      case (state_q)
        StIdle: begin
          if (cand_any) begin
            code_q  <= cand_code;
            valid_q <= 1'b1;
            state_q <= StPresent;
          end
        end
        StPresent: begin
          if (bus.ready) begin
            if (cand_any) begin
              code_q <= cand_code;
            end else begin
              valid_q <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.code    = code_q;
  assign bus.valid   = valid_q;
  assign bus.pending = pending_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_event_encoder_8_to_3.sv
// Bench for event_encoder_8_to_3: hand-derived vector table on the high-priority instance,
// plus a behavioural model checking both priority variants under random stimulus.
module tb_event_encoder_8_to_3;
  import encoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ready;
  logic       clr_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  event_encoder_8_to_3_if bus_hi ();
  event_encoder_8_to_3_if bus_lo ();

  assign bus_hi.req     = req;
  assign bus_hi.mask    = mask;
  assign bus_hi.ready   = ready;
  assign bus_hi.clr_ovf = clr_ovf;
  assign bus_lo.req     = req;
  assign bus_lo.mask    = mask;
  assign bus_lo.ready   = ready;
  assign bus_lo.clr_ovf = clr_ovf;

  event_encoder_8_to_3 #(.PRIORITY_HIGH(1'b1)) dut_hi (.clk(clk), .rst(rst), .bus(bus_hi));
  event_encoder_8_to_3 #(.PRIORITY_HIGH(1'b0)) dut_lo (.clk(clk), .rst(rst), .bus(bus_lo));

  typedef struct packed {
    logic [7:0] req_q;
    logic [7:0] pending;
    logic [7:0] ovf;
    logic       valid;
    logic [2:0] code;
  } mstate_t;

  mstate_t m_hi = '0;
  mstate_t m_lo = '0;

  // One clock of the encoder, stated bit by bit from the event rules.
  function automatic mstate_t model_step(mstate_t s, bit hi, logic r_rst, logic [7:0] r_req,
                                         logic [7:0] r_mask, logic r_ready, logic r_clr);
    mstate_t n;
    int      pick;
    bit      rose;
    bit      taken;
    n       = s;
    n.req_q = r_req;
    if (r_rst) begin
      n.pending = '0;
      n.ovf     = '0;
      n.valid   = 1'b0;
      n.code    = '0;
      return n;
    end
    pick = -1;
    for (int i = 0; i < 8; i++) begin
      rose         = r_req[i] && !s.req_q[i];
      taken        = s.valid && r_ready && (int'(s.code) == i);
      n.pending[i] = (s.pending[i] && !taken) || rose;
      n.ovf[i]     = (s.ovf[i] && !r_clr) || (rose && s.pending[i] && !taken);
      if (s.pending[i] && r_mask[i] && (!taken || rose)) begin
        if (pick < 0 || hi) pick = i;
      end
    end
    if (!s.valid || r_ready) begin
      if (pick >= 0) begin
        n.valid = 1'b1;
        n.code  = 3'(pick);
      end else begin
        n.valid = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    mstate_t nh;
    mstate_t nl;
    nh = model_step(m_hi, 1'b1, rst, req, mask, ready, clr_ovf);
    nl = model_step(m_lo, 1'b0, rst, req, mask, ready, clr_ovf);
    @(posedge clk);
    #1;
    m_hi = nh;
    m_lo = nl;
  endtask

  task automatic check_lo_model();
    chk("lo_valid", 8'(bus_lo.valid), 8'(m_lo.valid));
    chk("lo_code", 8'(bus_lo.code), 8'(m_lo.code));
    chk("lo_pending", bus_lo.pending, m_lo.pending);
    chk("lo_ovf", bus_lo.ovf, m_lo.ovf);
  endtask

  task automatic check_hi_model();
    chk("hi_valid", 8'(bus_hi.valid), 8'(m_hi.valid));
    chk("hi_code", 8'(bus_hi.code), 8'(m_hi.code));
    chk("hi_pending", bus_hi.pending, m_hi.pending);
    chk("hi_ovf", bus_hi.ovf, m_hi.ovf);
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ready;
    logic       clr;
    logic       ev;
    logic [2:0] ec;
    logic [7:0] ep;
    logic [7:0] eo;
    logic       chk_lo;
    logic [2:0] lo_code;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [7:0] rq, input logic [7:0] mk, input logic rd,
                     input logic cl, input logic ev, input logic [2:0] ec, input logic [7:0] ep,
                     input logic [7:0] eo, input logic cl_lo, input logic [2:0] lc);
    vec_t v;
    v = '{r, rq, mk, rd, cl, ev, ec, ep, eo, cl_lo, lc};
    vecs.push_back(v);
  endtask

  initial begin
    int lat;
    rst     = 1'b1;
    req     = 8'h00;
    mask    = 8'hFF;
    ready   = 1'b1;
    clr_ovf = 1'b0;

    // rst req mask rdy clr | valid code pending ovf | lo-check lo-code
    // Single event, held request
    add(1, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    add(1, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    add(0, 8'h10, 8'hFF, 1, 0, 0, 0, 8'h10, 8'h00, 0, 0);
    add(0, 8'h10, 8'hFF, 1, 0, 1, 4, 8'h10, 8'h00, 0, 0);
    add(0, 8'h10, 8'hFF, 1, 0, 0, 4, 8'h00, 8'h00, 0, 0);
    add(0, 8'h10, 8'hFF, 1, 0, 0, 4, 8'h00, 8'h00, 0, 0);
    // Priority 8'h81 with ready low, then drained
    add(0, 8'h00, 8'hFF, 0, 0, 0, 4, 8'h00, 8'h00, 0, 0);
    add(0, 8'h81, 8'hFF, 0, 0, 0, 4, 8'h81, 8'h00, 0, 0);
    add(0, 8'h81, 8'hFF, 0, 0, 1, 7, 8'h81, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 8'h81, 8'hFF, 0, 0, 1, 7, 8'h81, 8'h00, 0, 0);
    add(0, 8'h81, 8'hFF, 1, 0, 1, 0, 8'h01, 8'h00, 1, 7);
    add(0, 8'h81, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 1, 7);
    // Masked pending, then unmasked
    add(0, 8'h00, 8'hFB, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    add(0, 8'h04, 8'hFB, 1, 0, 0, 0, 8'h04, 8'h00, 0, 0);
    add(0, 8'h04, 8'hFB, 1, 0, 0, 0, 8'h04, 8'h00, 0, 0);
    add(0, 8'h04, 8'hFF, 1, 0, 1, 2, 8'h04, 8'h00, 0, 0);
    add(0, 8'h04, 8'hFF, 1, 0, 0, 2, 8'h00, 8'h00, 0, 0);
    // Overflow on index 3 while 5 is held, clear, and set-beats-clear
    add(0, 8'h20, 8'hFF, 0, 0, 0, 2, 8'h20, 8'h00, 0, 0);
    add(0, 8'h20, 8'hFF, 0, 0, 1, 5, 8'h20, 8'h00, 0, 0);
    add(0, 8'h28, 8'hFF, 0, 0, 1, 5, 8'h28, 8'h00, 0, 0);
    add(0, 8'h20, 8'hFF, 0, 0, 1, 5, 8'h28, 8'h00, 0, 0);
    add(0, 8'h28, 8'hFF, 0, 0, 1, 5, 8'h28, 8'h08, 0, 0);
    add(0, 8'h20, 8'hFF, 0, 1, 1, 5, 8'h28, 8'h00, 0, 0);
    add(0, 8'h28, 8'hFF, 0, 1, 1, 5, 8'h28, 8'h08, 0, 0);
    add(0, 8'h20, 8'hFF, 0, 1, 1, 5, 8'h28, 8'h00, 0, 0);
    // Re-rise of index 5 in its own accept cycle
    add(0, 8'h00, 8'hFF, 0, 0, 1, 5, 8'h28, 8'h00, 0, 0);
    add(0, 8'h20, 8'hFF, 1, 0, 1, 5, 8'h28, 8'h00, 0, 0);
    add(0, 8'h20, 8'hFF, 1, 0, 1, 3, 8'h08, 8'h00, 0, 0);
    add(0, 8'h20, 8'hFF, 1, 0, 0, 3, 8'h00, 8'h00, 0, 0);
    // Reset while presenting, request held through reset
    add(0, 8'h00, 8'hFF, 0, 0, 0, 3, 8'h00, 8'h00, 0, 0);
    add(0, 8'hF0, 8'hFF, 0, 0, 0, 3, 8'hF0, 8'h00, 0, 0);
    add(0, 8'hF0, 8'hFF, 0, 0, 1, 7, 8'hF0, 8'h00, 0, 0);
    add(1, 8'hF0, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    add(0, 8'hF0, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    add(0, 8'hF0, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      rst     = vecs[i].rst;
      req     = vecs[i].req;
      mask    = vecs[i].mask;
      ready   = vecs[i].ready;
      clr_ovf = vecs[i].clr;
      cycle();
      chk($sformatf("vec%0d_valid", i), 8'(bus_hi.valid), 8'(vecs[i].ev));
      chk($sformatf("vec%0d_code", i), 8'(bus_hi.code), 8'(vecs[i].ec));
      chk($sformatf("vec%0d_pending", i), bus_hi.pending, vecs[i].ep);
      chk($sformatf("vec%0d_ovf", i), bus_hi.ovf, vecs[i].eo);
      if (vecs[i].chk_lo) begin
        chk($sformatf("vec%0d_lo_valid", i), 8'(bus_lo.valid), 8'(vecs[i].ev));
        chk($sformatf("vec%0d_lo_code", i), 8'(bus_lo.code), 8'(vecs[i].lo_code));
      end
      check_lo_model();
    end

    // Edge-to-valid latency on the low-priority instance, bounded wait
    req   = 8'h00;
    ready = 1'b0;
    cycle();
    req = 8'h40;
    lat = 0;
    while (!bus_lo.valid && lat < 10) begin
      cycle();
      lat++;
    end
    chk("latency_lo", 8'(lat), 8'd2);
    chk("latency_lo_code", 8'(bus_lo.code), 8'd6);
    ready = 1'b1;
    cycle();
    check_lo_model();
    check_hi_model();

    // Random traffic against the model, both priority variants
    for (int n = 0; n < 2000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      req     = req ^ (8'($urandom) & 8'($urandom));
      mask    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      ready   = ($urandom_range(0, 3) != 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      cycle();
      check_hi_model();
      check_lo_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
